// File: rtl/step_counter_ctrl.sv
// Purpose : parametrised up/down step counter with runtime step, runtime
//           inclusive limits and saturate / wrap / bounce limit handling.
// Latency : o_out and o_limit_evt update one clock after i_en/i_load are
//           sampled; o_stepwidth_out, o_at_hi, o_at_lo, o_cfg_err are
//           combinational.
// Backpressure: none; the counter advances every cycle i_en is high.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_en                  advance one step this cycle
//   i_upnotdown           direction (modes 00/01/11), seeds direction in mode 10
//   i_mode                00 saturate, 01 wrap, 10 bounce, 11 as saturate
//   i_step_sel, i_step_in 0: DEFAULT_STEP, 1: i_step_in
//   i_limit_lo/hi         inclusive bounds
//   i_load, i_load_value  synchronous load (clamped into bounds)
//   o_out                 current count
//   o_stepwidth_out       effective step
//   o_dir                 effective direction, 1 = up
//   o_at_hi, o_at_lo      count equals a bound
//   o_limit_evt           one-cycle pulse on clamp, wrap or reversal
//   o_cfg_err             i_limit_lo > i_limit_hi
module step_counter_ctrl #(
  parameter int WIDTH        = 16,
  parameter int RESET_VALUE  = 0,
  parameter int DEFAULT_STEP = 100
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_upnotdown,
  input  logic [1:0]       i_mode,
  input  logic             i_step_sel,
  input  logic [WIDTH-1:0] i_step_in,
  input  logic [WIDTH-1:0] i_limit_lo,
  input  logic [WIDTH-1:0] i_limit_hi,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic [WIDTH-1:0] o_out,
  output logic [WIDTH-1:0] o_stepwidth_out,
  output logic             o_dir,
  output logic             o_at_hi,
  output logic             o_at_lo,
  output logic             o_limit_evt,
  output logic             o_cfg_err
);

  localparam logic [WIDTH-1:0] LP_RESET = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] LP_DSTEP = WIDTH'(DEFAULT_STEP);

  typedef enum logic [1:0] {
    MODE_SAT  = 2'b00,
    MODE_WRAP = 2'b01,
    MODE_BNC  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  // State
  logic [WIDTH-1:0] r_out;
  logic             r_evt;
  logic             r_bdir;    // bounce direction, 1 = up
  logic             r_in_bnc;  // mode was bounce on the previous cycle

  // Combinational
  mode_e            w_mode;
  logic             w_is_wrap;
  logic             w_is_bnc;
  logic [WIDTH-1:0] w_step;
  logic             w_cfg_err;
  logic             w_bnc_dir;
  logic             w_dir;
  logic [WIDTH:0]   w_c_ext;
  logic [WIDTH:0]   w_lo_ext;
  logic [WIDTH:0]   w_hi_ext;
  logic [WIDTH:0]   w_s_ext;
  logic [WIDTH:0]   w_ld_ext;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_lo_plus;
  logic [WIDTH:0]   w_diff;
  logic             w_under;
  logic [WIDTH-1:0] w_nxt_out;
  logic             w_nxt_evt;
  logic             w_nxt_bdir;

  assign w_mode    = mode_e'(i_mode);
  assign w_is_wrap = (w_mode == MODE_WRAP);
  assign w_is_bnc  = (w_mode == MODE_BNC);
  assign w_step    = i_step_sel ? i_step_in : LP_DSTEP;
  assign w_cfg_err = (i_limit_lo > i_limit_hi);

  // On the first cycle after entering bounce mode the register has not yet
  // been seeded, so take the direction straight from i_upnotdown.
  assign w_bnc_dir = (w_is_bnc && !r_in_bnc) ? i_upnotdown : r_bdir;
  assign w_dir     = w_is_bnc ? w_bnc_dir : i_upnotdown;

  // One extra bit on every sum/difference so overflow is always visible.
  assign w_c_ext   = {1'b0, r_out};
  assign w_lo_ext  = {1'b0, i_limit_lo};
  assign w_hi_ext  = {1'b0, i_limit_hi};
  assign w_s_ext   = {1'b0, w_step};
  assign w_ld_ext  = {1'b0, i_load_value};
  assign w_sum     = w_c_ext + w_s_ext;
  assign w_lo_plus = w_lo_ext + w_s_ext;
  assign w_diff    = w_c_ext - w_s_ext;
  // A borrow out of c-S already implies c < lo+S; both are tested so the
  // borrow bit can never be dropped on the floor.
  assign w_under   = w_diff[WIDTH] || (w_c_ext < w_lo_plus);

  always_comb begin
    w_nxt_out  = r_out;
    w_nxt_evt  = 1'b0;
    w_nxt_bdir = w_bnc_dir;
    if (!w_cfg_err) begin
      if (i_load) begin
        if (w_ld_ext > w_hi_ext) begin
          w_nxt_out = i_limit_hi;
          w_nxt_evt = 1'b1;
        end else if (w_ld_ext < w_lo_ext) begin
          w_nxt_out = i_limit_lo;
          w_nxt_evt = 1'b1;
        end else begin
          w_nxt_out = i_load_value;
        end
        if (w_is_bnc) begin
          w_nxt_bdir = i_upnotdown;
        end
      end else if (i_en) begin
        // Limits moved under the count: snap back, no step this cycle.
        if (w_c_ext > w_hi_ext) begin
          w_nxt_out = i_limit_hi;
        end else if (w_c_ext < w_lo_ext) begin
          w_nxt_out = i_limit_lo;
        end else if (w_step != '0) begin
          if (w_is_bnc) begin
            if (w_bnc_dir) begin
              if (w_sum >= w_hi_ext) begin
                w_nxt_out  = i_limit_hi;
                w_nxt_evt  = 1'b1;
                w_nxt_bdir = 1'b0;
              end else begin
                w_nxt_out = w_sum[WIDTH-1:0];
              end
            end else begin
              if (w_under || (w_c_ext == w_lo_plus)) begin
                w_nxt_out  = i_limit_lo;
                w_nxt_evt  = 1'b1;
                w_nxt_bdir = 1'b1;
              end else begin
                w_nxt_out = w_diff[WIDTH-1:0];
              end
            end
          end else begin
            // Saturate and wrap share the overflow tests; they differ only
            // in which bound is loaded when the step would cross a limit.
            if (i_upnotdown) begin
              if (w_sum > w_hi_ext) begin
                w_nxt_out = w_is_wrap ? i_limit_lo : i_limit_hi;
                w_nxt_evt = 1'b1;
              end else begin
                w_nxt_out = w_sum[WIDTH-1:0];
              end
            end else begin
              if (w_under) begin
                w_nxt_out = w_is_wrap ? i_limit_hi : i_limit_lo;
                w_nxt_evt = 1'b1;
              end else begin
                w_nxt_out = w_diff[WIDTH-1:0];
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out    <= LP_RESET;
      r_evt    <= 1'b0;
      r_bdir   <= 1'b1;
      // Treat reset as already in bounce so the reset direction (up) is used
      // if the block comes out of reset in bounce mode.
      r_in_bnc <= 1'b1;
    end else begin
      r_out    <= w_nxt_out;
      r_evt    <= w_nxt_evt;
      r_bdir   <= w_nxt_bdir;
      r_in_bnc <= w_is_bnc;
    end
  end

  assign o_out           = r_out;
  assign o_stepwidth_out = w_step;
  assign o_dir           = w_dir;
  assign o_at_hi         = (r_out == i_limit_hi);
  assign o_at_lo         = (r_out == i_limit_lo);
  assign o_limit_evt     = r_evt;
  assign o_cfg_err       = w_cfg_err;

endmodule

// File: tb/tb_step_counter_ctrl.sv
// Purpose : self-checking bench for step_counter_ctrl (WIDTH=16).
// Latency : directed vectors issued one per clock; registered expectations
//           fall due one clock after issue, combinational ones immediately.
// Backpressure: none; a monitor drains the expectation queue each negedge.
module tb_step_counter_ctrl;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         en;
  logic         upd;
  logic [1:0]   mode;
  logic         ssel;
  logic [W-1:0] sin;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic         load;
  logic [W-1:0] lval;
  logic [W-1:0] out;
  logic [W-1:0] sw_out;
  logic         dir;
  logic         at_hi;
  logic         at_lo;
  logic         evt;
  logic         cfg_err;

  step_counter_ctrl #(.WIDTH(W), .RESET_VALUE(0), .DEFAULT_STEP(100)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_upnotdown(upd), .i_mode(mode),
    .i_step_sel(ssel), .i_step_in(sin), .i_limit_lo(lo), .i_limit_hi(hi),
    .i_load(load), .i_load_value(lval), .o_out(out),
    .o_stepwidth_out(sw_out), .o_dir(dir), .o_at_hi(at_hi), .o_at_lo(at_lo),
    .o_limit_evt(evt), .o_cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           due;
    int           id;
    bit           is_comb;
    logic [W-1:0] out;
    logic         evt;
    logic         dir;
    logic         cfg;
    logic [W-1:0] sw;
    logic         ahi;
    logic         alo;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  int           n_total = 0;
  int           n_pass = 0;
  int           vec_id = 0;
  logic [W-1:0] cur_out;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] expv);
    n_total++;
    if (act !== expv)
      $display("FAIL %s vec%0d: got %0d expected %0d", name, id, act, expv);
    else
      n_pass++;
  endtask

  // Monitor: compares every expectation whose clock edge has passed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.is_comb) begin
          chk("dir", e.id, {31'd0, dir}, {31'd0, e.dir});
          chk("cfg_err", e.id, {31'd0, cfg_err}, {31'd0, e.cfg});
          chk("stepwidth", e.id, {16'd0, sw_out}, {16'd0, e.sw});
          chk("at_hi", e.id, {31'd0, at_hi}, {31'd0, e.ahi});
          chk("at_lo", e.id, {31'd0, at_lo}, {31'd0, e.alo});
        end else begin
          chk("out", e.id, {16'd0, out}, {16'd0, e.out});
          chk("limit_evt", e.id, {31'd0, evt}, {31'd0, e.evt});
        end
      end
    end
  end

  // One directed vector: inputs for the next edge, hand-computed result
  // after that edge (eo, ee) and direction expected during this cycle (ed).
  task automatic v(input logic v_en, input logic v_ld, input int v_lv,
                   input logic v_upd, input logic [1:0] v_mode,
                   input logic v_ssel, input int v_sin, input int v_lo,
                   input int v_hi, input int eo, input logic ee,
                   input logic ed);
    exp_t c;
    exp_t r;
    @(posedge clk);
    #1;
    en = v_en; load = v_ld; lval = W'(v_lv); upd = v_upd; mode = v_mode;
    ssel = v_ssel; sin = W'(v_sin); lo = W'(v_lo); hi = W'(v_hi);
    vec_id++;
    c.due = cyc; c.id = vec_id; c.is_comb = 1'b1;
    c.out = '0; c.evt = 1'b0; c.dir = ed;
    c.cfg = (v_lo > v_hi);
    c.sw  = v_ssel ? W'(v_sin) : W'(100);
    c.ahi = (cur_out == W'(v_hi));
    c.alo = (cur_out == W'(v_lo));
    q.push_back(c);
    r.due = cyc + 1; r.id = vec_id; r.is_comb = 1'b0;
    r.out = W'(eo); r.evt = ee; r.dir = 1'b0; r.cfg = 1'b0;
    r.sw = '0; r.ahi = 1'b0; r.alo = 1'b0;
    q.push_back(r);
    cur_out = W'(eo);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; upd = 1'b1; mode = 2'b00; ssel = 1'b0; sin = '0;
    lo = '0; hi = '1; load = 1'b0; lval = '0; cur_out = '0;
    #3;
    chk("reset_out", 0, {16'd0, out}, 32'd0);
    chk("reset_evt", 0, {31'd0, evt}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    //  en ld lval  upd mode  ss sin lo   hi     exp_out ev dir
    // Count to 300, then reset asynchronously between edges
    v(1, 0, 0,     1, 2'b00, 0, 0,   0,  65535, 100,   0, 1);
    v(1, 0, 0,     1, 2'b00, 0, 0,   0,  65535, 200,   0, 1);
    v(1, 0, 0,     1, 2'b00, 0, 0,   0,  65535, 300,   0, 1);
    @(posedge clk);
    #1 en = 1'b0; load = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1; mode = 2'b10; upd = 1'b0;
    #1;
    chk("async_rst_out", 0, {16'd0, out}, 32'd0);
    chk("async_rst_evt", 0, {31'd0, evt}, 32'd0);
    chk("async_rst_dir", 0, {31'd0, dir}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    cur_out = '0;

    // Saturate
    v(0, 1, 65400, 1, 2'b00, 0, 0,   0,  65535, 65400, 0, 1);
    v(1, 0, 0,     1, 2'b00, 0, 0,   0,  65535, 65500, 0, 1);
    v(1, 0, 0,     1, 2'b00, 0, 0,   0,  65535, 65535, 1, 1);
    v(1, 0, 0,     1, 2'b00, 0, 0,   0,  65535, 65535, 1, 1);
    v(1, 0, 0,     1, 2'b00, 0, 0,   0,  65535, 65535, 1, 1);
    v(0, 1, 150,   0, 2'b00, 0, 0,   0,  65535, 150,   0, 0);
    v(1, 0, 0,     0, 2'b00, 0, 0,   0,  65535, 50,    0, 0);
    v(1, 0, 0,     0, 2'b00, 0, 0,   0,  65535, 0,     1, 0);
    v(1, 0, 0,     0, 2'b00, 0, 0,   0,  65535, 0,     1, 0);
    // Mode 11 behaves as saturate
    v(0, 1, 65500, 1, 2'b11, 0, 0,   0,  65535, 65500, 0, 1);
    v(1, 0, 0,     1, 2'b11, 0, 0,   0,  65535, 65535, 1, 1);
    // Wrap
    v(0, 1, 10,    1, 2'b01, 1, 200, 10, 500,   10,    0, 1);
    v(1, 0, 0,     1, 2'b01, 1, 200, 10, 500,   210,   0, 1);
    v(1, 0, 0,     1, 2'b01, 1, 200, 10, 500,   410,   0, 1);
    v(1, 0, 0,     1, 2'b01, 1, 200, 10, 500,   10,    1, 1);
    v(0, 1, 100,   0, 2'b01, 1, 200, 10, 500,   100,   0, 0);
    v(1, 0, 0,     0, 2'b01, 1, 200, 10, 500,   500,   1, 0);
    // Bounce: direction seeded by load, then upnotdown is ignored
    v(0, 1, 0,     1, 2'b10, 1, 300, 0,  1000,  0,     0, 1);
    v(1, 0, 0,     0, 2'b10, 1, 300, 0,  1000,  300,   0, 1);
    v(1, 0, 0,     0, 2'b10, 1, 300, 0,  1000,  600,   0, 1);
    v(1, 0, 0,     0, 2'b10, 1, 300, 0,  1000,  900,   0, 1);
    v(1, 0, 0,     0, 2'b10, 1, 300, 0,  1000,  1000,  1, 1);
    v(1, 0, 0,     0, 2'b10, 1, 300, 0,  1000,  700,   0, 0);
    v(1, 0, 0,     0, 2'b10, 1, 300, 0,  1000,  400,   0, 0);
    v(1, 0, 0,     0, 2'b10, 1, 300, 0,  1000,  100,   0, 0);
    v(1, 0, 0,     0, 2'b10, 1, 300, 0,  1000,  0,     1, 0);
    v(1, 0, 0,     0, 2'b10, 1, 300, 0,  1000,  300,   0, 1);
    // Load clamp, invalid configuration, out-of-range recovery
    v(0, 1, 2000,  0, 2'b00, 0, 0,   0,  1000,  1000,  1, 0);
    v(1, 1, 5,     0, 2'b00, 0, 0,   800, 700,  1000,  0, 0);
    v(1, 0, 0,     0, 2'b00, 0, 0,   800, 700,  1000,  0, 0);
    v(1, 0, 0,     1, 2'b00, 0, 0,   0,  500,   500,   0, 1);
    v(1, 0, 0,     1, 2'b00, 0, 0,   0,  500,   500,   1, 1);
    // Load beats en; zero step holds in both directions
    v(1, 1, 123,   1, 2'b00, 0, 0,   0,  500,   123,   0, 1);
    v(1, 0, 0,     1, 2'b00, 1, 0,   0,  500,   123,   0, 1);
    v(1, 0, 0,     0, 2'b00, 1, 0,   0,  500,   123,   0, 0);
    // Equal limits: recovery, wrap, then bounce reversing every cycle
    v(1, 0, 0,     1, 2'b01, 0, 0,   200, 200,  200,   0, 1);
    v(1, 0, 0,     1, 2'b01, 0, 0,   200, 200,  200,   1, 1);
    v(1, 0, 0,     1, 2'b10, 0, 0,   200, 200,  200,   1, 1);
    v(1, 0, 0,     1, 2'b10, 0, 0,   200, 200,  200,   1, 0);
    v(1, 0, 0,     1, 2'b10, 0, 0,   200, 200,  200,   1, 1);
    // Idle: count holds, event clears
    v(0, 0, 0,     1, 2'b10, 0, 0,   200, 200,  200,   0, 0);

    @(posedge clk);
    #1 en = 1'b0; load = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
